vp_gfx_bitmap_pipe: RTL and testbench

Parametrised, pipelined successor to the video-pipeline graphic-character expander. It takes a per-cell graphic bit pattern (GFX_COLS x GFX_ROWS blocks) and the current character pixel row. It produces the CHAR_WIDTH-pixel bitmap line plus colours for the pixel serialiser. New over the previous generation:
- generic cell geometry
- 2-stage pipeline with hold (stall)
- double-height rendering
- out-of-range row blanking
- optional blink

---
 rtl/vp_gfx_bitmap_pipe.sv | 162 ++++++++++++++++
 tb/tb_vp_gfx_bitmap_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_gfx_bitmap_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vp_gfx_bitmap_pipe                                           |
// | Description : Two-stage pipelined graphic-character expander. Turns a      |
// |               GFX_COLS x GFX_ROWS block pattern plus the current pixel row |
// |               into a CHAR_WIDTH-pixel bitmap line with colours. Supports   |
// |               separated (mosaic) blocks, double height, out-of-range row   |
// |               blanking and a pipeline hold.                                |
// |               Optional blink: define VP_GFX_BLINK_EN to build the blink    |
// |               counter; otherwise blink/frame_tick are ignored.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vp_gfx_bitmap_pipe #(
  parameter int CHAR_WIDTH  = 16,
  parameter int CHAR_HEIGHT = 20,
  parameter int GFX_COLS    = 4,
  parameter int GFX_ROWS    = 5,
  parameter int ROW_WIDTH   = 5,
  parameter int COLOR_WIDTH = 4,
  parameter int BLINK_DIV   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COLOR_WIDTH-1:0]       foreground,
  input  logic [COLOR_WIDTH-1:0]       background,
  input  logic [GFX_COLS*GFX_ROWS-1:0] gfx_bits,
  input  logic [ROW_WIDTH-1:0]         char_row,
  input  logic                         mosaic,
  input  logic                         dbl_height,
  input  logic                         dbl_bottom,
  input  logic                         blink,
  input  logic                         frame_tick,
  input  logic                         hold,
  input  logic                         enabled,
  output logic [COLOR_WIDTH-1:0]       gfx_foreground,
  output logic [COLOR_WIDTH-1:0]       gfx_background,
  output logic [CHAR_WIDTH-1:0]        gfx_bitmap,
  output logic                         enable
);

  localparam int CELL_W = CHAR_WIDTH / GFX_COLS;
  localparam int CELL_H = CHAR_HEIGHT / GFX_ROWS;
  // One extra bit so the double-height bottom-half offset never overflows.
  localparam int ER_W = ROW_WIDTH + 1;
  localparam logic [ER_W-1:0]   HALF_ROWS   = ER_W'(CHAR_HEIGHT / 2);
  localparam logic [ER_W-1:0]   CELL_H_V    = ER_W'(CELL_H);
  localparam logic [ER_W-1:0]   HEIGHT_V    = ER_W'(CHAR_HEIGHT);
  localparam logic [CELL_W-1:0] RIGHT_PIXEL = CELL_W'(1);

  logic suppress;

`ifdef VP_GFX_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  // Blink divider: counts frames regardless of hold, toggles phase on wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  assign suppress = blink && blink_phase;
`else
  logic unused_blink;
  assign unused_blink = blink ^ frame_tick;
  assign suppress     = 1'b0;
`endif

  logic [ER_W-1:0]     eff_row;
  logic [ER_W-1:0]     block_row;
  logic [ER_W-1:0]     row_in_cell;
  logic [GFX_COLS-1:0] row_slice;
  logic                gap;
  logic                out_of_range;

  // Stage-1 decode: effective row, block row selection, gap and range tests.
  always_comb begin
    eff_row = {1'b0, char_row};
    if (dbl_height) begin
      eff_row = {2'b00, char_row[ROW_WIDTH-1:1]} + (dbl_bottom ? HALF_ROWS : '0);
    end
    block_row    = eff_row / CELL_H_V;
    row_in_cell  = eff_row % CELL_H_V;
    gap          = mosaic && (row_in_cell == CELL_H_V - ER_W'(1));
    out_of_range = ({1'b0, char_row} >= HEIGHT_V);
    row_slice    = '0;
    for (int r = 0; r < GFX_ROWS; r++) begin
      if (block_row == ER_W'(r)) begin
        row_slice = gfx_bits[(GFX_ROWS - r) * GFX_COLS - 1 -: GFX_COLS];
      end
    end
  end

  logic                   s1_valid;
  logic [COLOR_WIDTH-1:0] s1_fg;
  logic [COLOR_WIDTH-1:0] s1_bg;
  logic [GFX_COLS-1:0]    s1_slice;
  logic                   s1_mosaic;
  logic                   s1_blank;

  // Stage-1 register: data only loads on valid input so bubbles carry nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_fg     <= '0;
      s1_bg     <= '0;
      s1_slice  <= '0;
      s1_mosaic <= 1'b0;
      s1_blank  <= 1'b0;
    end else if (!hold) begin
      s1_valid <= enabled;
      if (enabled) begin
        s1_fg     <= foreground;
        s1_bg     <= background;
        s1_slice  <= row_slice;
        s1_mosaic <= mosaic;
        s1_blank  <= gap || out_of_range || suppress;
      end
    end
  end

  logic [CHAR_WIDTH-1:0] line;

  // Stage-2 expansion: slice bit j drives cell j counted from the right.
  generate
    for (genvar j = 0; j < GFX_COLS; j++) begin : g_cell
      assign line[j*CELL_W +: CELL_W] = s1_blank ? '0 :
             ({CELL_W{s1_slice[j]}} & ~(s1_mosaic ? RIGHT_PIXEL : '0));
    end
  endgenerate

  // Output register: data holds across bubbles, only enable follows valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable         <= 1'b0;
      gfx_foreground <= '0;
      gfx_background <= '0;
      gfx_bitmap     <= '0;
    end else if (!hold) begin
      enable <= s1_valid;
      if (s1_valid) begin
        gfx_foreground <= s1_fg;
        gfx_background <= s1_bg;
        gfx_bitmap     <= line;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vp_gfx_bitmap_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vp_gfx_bitmap_pipe                                        |
// | Description : Self-checking bench for vp_gfx_bitmap_pipe (BLINK_DIV = 2).  |
// |               Blink expectations follow VP_GFX_BLINK_EN.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vp_gfx_bitmap_pipe;

  localparam int BD = 2;
  localparam logic [19:0] PAT = 20'b1010_0101_0000_1111_1001;

  logic        clk = 1'b0;
  logic        reset, mosaic, dbl_height, dbl_bottom, blink, frame_tick, hold, enabled;
  logic [3:0]  foreground, background;
  logic [19:0] gfx_bits;
  logic [4:0]  char_row;
  logic [3:0]  gfx_foreground, gfx_background;
  logic [15:0] gfx_bitmap;
  logic        enable;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic [15:0] bmp;
  } line_t;

  line_t       hist[$];
  int          ticks;
  logic        exp_en;
  logic [3:0]  exp_fg, exp_bg;
  logic [15:0] exp_bmp;

  always #5 clk = ~clk;

  vp_gfx_bitmap_pipe #(.BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .foreground(foreground), .background(background),
    .gfx_bits(gfx_bits), .char_row(char_row), .mosaic(mosaic),
    .dbl_height(dbl_height), .dbl_bottom(dbl_bottom), .blink(blink),
    .frame_tick(frame_tick), .hold(hold), .enabled(enabled),
    .gfx_foreground(gfx_foreground), .gfx_background(gfx_background),
    .gfx_bitmap(gfx_bitmap), .enable(enable)
  );

  // Pixel-by-pixel rendering of one line straight from the character geometry.
  function automatic logic [15:0] ref_line(input int row, input logic [19:0] bits,
                                           input logic mos, input logic dh,
                                           input logic db, input logic sup);
    int eff, gr;
    logic [15:0] l;
    l = '0;
    if (row >= 20 || sup) return l;
    eff = dh ? (row / 2 + (db ? 10 : 0)) : row;
    if (mos && (eff % 4 == 3)) return l;
    gr = eff / 4;
    for (int p = 0; p < 16; p++) begin
      if (!(mos && (p % 4 == 3))) l[15-p] = bits[19 - (gr * 4 + p / 4)];
    end
    return l;
  endfunction

  function automatic logic phase_on();
`ifdef VP_GFX_BLINK_EN
    return ((ticks / BD) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: model records accepted lines; output is the one accepted two
  // non-held edges ago, with data sticking to the last valid line.
  task automatic cycle();
    line_t e;
    @(posedge clk);
    if (reset) begin
      hist.delete();
      ticks   = 0;
      exp_en  = 1'b0;
      exp_fg  = '0;
      exp_bg  = '0;
      exp_bmp = '0;
    end else begin
      if (!hold) begin
        e.valid = enabled;
        e.fg    = foreground;
        e.bg    = background;
        e.bmp   = ref_line(int'(char_row), gfx_bits, mosaic, dbl_height, dbl_bottom,
                           blink && phase_on());
        hist.push_back(e);
        if (hist.size() >= 2) begin
          e = hist[hist.size()-2];
          exp_en = e.valid;
          if (e.valid) begin
            exp_fg  = e.fg;
            exp_bg  = e.bg;
            exp_bmp = e.bmp;
          end
        end
        if (hist.size() > 2) void'(hist.pop_front());
      end
      if (frame_tick) ticks++;
    end
    #1;
  endtask

  task automatic base_inputs();
    reset = 1'b0; mosaic = 1'b0; dbl_height = 1'b0; dbl_bottom = 1'b0;
    blink = 1'b0; frame_tick = 1'b0; hold = 1'b0; enabled = 1'b1;
    foreground = 4'd1; background = 4'd2; gfx_bits = PAT; char_row = '0;
  endtask

  task automatic test_reset();
    base_inputs();
    reset = 1'b1; enabled = 1'b1; foreground = 4'hF; background = 4'hE;
    cycle(); cycle();
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b want=0", enable); end
    checks++; if (gfx_bitmap !== 16'h0) begin failures++; $display("FAIL reset_bitmap got=%h want=0000", gfx_bitmap); end
    checks++; if (gfx_foreground !== 4'h0) begin failures++; $display("FAIL reset_fg got=%h want=0", gfx_foreground); end
    checks++; if (gfx_background !== 4'h0) begin failures++; $display("FAIL reset_bg got=%h want=0", gfx_background); end
    reset = 1'b0;
  endtask

  task automatic test_solid();
    int          rows[3] = '{0, 4, 16};
    logic [15:0] exps[3] = '{16'hF0F0, 16'h0F0F, 16'hF00F};
    base_inputs();
    for (int i = 0; i < 3; i++) begin
      char_row = 5'(rows[i]);
      cycle(); cycle();
      checks++; if (gfx_bitmap !== exps[i]) begin failures++; $display("FAIL solid_row%0d got=%h want=%h", rows[i], gfx_bitmap, exps[i]); end
      checks++; if (enable !== 1'b1) begin failures++; $display("FAIL solid_en_row%0d got=%b want=1", rows[i], enable); end
      checks++; if (gfx_foreground !== 4'd1 || gfx_background !== 4'd2) begin
        failures++; $display("FAIL solid_colours got=%h/%h want=1/2", gfx_foreground, gfx_background); end
    end
  endtask

  task automatic test_mosaic();
    int          rows[3] = '{1, 3, 17};
    logic [15:0] exps[3] = '{16'hE0E0, 16'h0000, 16'hE00E};
    base_inputs();
    mosaic = 1'b1;
    for (int i = 0; i < 3; i++) begin
      char_row = 5'(rows[i]);
      cycle(); cycle();
      checks++; if (gfx_bitmap !== exps[i] || enable !== 1'b1) begin
        failures++; $display("FAIL mosaic_row%0d got=%h/%b want=%h/1", rows[i], gfx_bitmap, enable, exps[i]); end
    end
  endtask

  task automatic test_dbl_height();
    logic        bots[3] = '{1'b0, 1'b1, 1'b1};
    int          rows[3] = '{8, 0, 12};
    logic [15:0] exps[3] = '{16'h0F0F, 16'h0000, 16'hF00F};
    base_inputs();
    dbl_height = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dbl_bottom = bots[i];
      char_row   = 5'(rows[i]);
      cycle(); cycle();
      checks++; if (gfx_bitmap !== exps[i] || enable !== 1'b1) begin
        failures++; $display("FAIL dbl_b%0d_row%0d got=%h/%b want=%h/1", bots[i], rows[i], gfx_bitmap, enable, exps[i]); end
    end
  endtask

  task automatic test_boundaries();
    int rows[2] = '{20, 31};
    base_inputs();
    for (int i = 0; i < 2; i++) begin
      char_row = 5'(rows[i]);
      cycle(); cycle();
      checks++; if (gfx_bitmap !== 16'h0 || enable !== 1'b1) begin
        failures++; $display("FAIL range_row%0d got=%h/%b want=0000/1", rows[i], gfx_bitmap, enable); end
    end
    // Single-cycle bubble between row 0 and row 4.
    char_row = 5'd0; cycle(); cycle();
    enabled = 1'b0; char_row = 5'd4; cycle();
    enabled = 1'b1; cycle();
    checks++; if (enable !== 1'b0 || gfx_bitmap !== 16'hF0F0) begin
      failures++; $display("FAIL bubble_out got=%h/%b want=f0f0/0", gfx_bitmap, enable); end
    cycle();
    checks++; if (enable !== 1'b1 || gfx_bitmap !== 16'h0F0F) begin
      failures++; $display("FAIL after_bubble got=%h/%b want=0f0f/1", gfx_bitmap, enable); end
  endtask

  task automatic test_hold();
    base_inputs();
    reset = 1'b1; cycle(); reset = 1'b0;
    char_row = 5'd0; cycle();
    char_row = 5'd4; cycle();
    checks++; if (gfx_bitmap !== 16'hF0F0 || enable !== 1'b1) begin
      failures++; $display("FAIL hold_pre got=%h/%b want=f0f0/1", gfx_bitmap, enable); end
    hold = 1'b1; char_row = 5'd12; foreground = 4'd9;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (gfx_bitmap !== 16'hF0F0 || enable !== 1'b1 || gfx_foreground !== 4'd1) begin
        failures++; $display("FAIL hold_frozen%0d got=%h/%b/%h want=f0f0/1/1", i, gfx_bitmap, enable, gfx_foreground); end
    end
    hold = 1'b0; char_row = 5'd8; foreground = 4'd1; cycle();
    checks++; if (gfx_bitmap !== 16'h0F0F || enable !== 1'b1) begin
      failures++; $display("FAIL hold_release_row4 got=%h/%b want=0f0f/1", gfx_bitmap, enable); end
    enabled = 1'b0; cycle();
    checks++; if (gfx_bitmap !== 16'h0000 || enable !== 1'b1) begin
      failures++; $display("FAIL hold_release_row8 got=%h/%b want=0000/1", gfx_bitmap, enable); end
  endtask

  task automatic test_reset_midstream();
    base_inputs();
    char_row = 5'd0; cycle(); cycle();
    reset = 1'b1; cycle();
    checks++; if (enable !== 1'b0 || gfx_bitmap !== 16'h0) begin
      failures++; $display("FAIL midreset got=%h/%b want=0000/0", gfx_bitmap, enable); end
    reset = 1'b0;
  endtask

  task automatic test_blink();
    logic [15:0] sup_exp;
`ifdef VP_GFX_BLINK_EN
    sup_exp = 16'h0000;
`else
    sup_exp = 16'hF0F0;
`endif
    base_inputs();
    reset = 1'b1; cycle(); reset = 1'b0;
    blink = 1'b1; foreground = 4'd3; background = 4'd4; char_row = 5'd0;
    frame_tick = 1'b1; cycle(); cycle(); frame_tick = 1'b0;
    cycle(); cycle();
    checks++; if (gfx_bitmap !== sup_exp || enable !== 1'b1 || gfx_foreground !== 4'd3 || gfx_background !== 4'd4) begin
      failures++; $display("FAIL blink_2ticks got=%h/%b/%h/%h want=%h/1/3/4", gfx_bitmap, enable, gfx_foreground, gfx_background, sup_exp); end
    frame_tick = 1'b1; cycle(); cycle(); frame_tick = 1'b0;
    cycle(); cycle();
    checks++; if (gfx_bitmap !== 16'hF0F0 || enable !== 1'b1) begin
      failures++; $display("FAIL blink_4ticks got=%h/%b want=f0f0/1", gfx_bitmap, enable); end
  endtask

  task automatic test_random();
    base_inputs();
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(99, 0) < 2);
      hold       = ($urandom_range(99, 0) < 20);
      enabled    = ($urandom_range(99, 0) < 80);
      frame_tick = ($urandom_range(99, 0) < 15);
      blink      = 1'($urandom);
      mosaic     = 1'($urandom);
      dbl_height = 1'($urandom);
      dbl_bottom = 1'($urandom);
      foreground = 4'($urandom);
      background = 4'($urandom);
      gfx_bits   = 20'($urandom);
      char_row   = 5'($urandom);
      cycle();
      checks++; if (enable !== exp_en || gfx_bitmap !== exp_bmp ||
                    gfx_foreground !== exp_fg || gfx_background !== exp_bg) begin
        failures++;
        $display("FAIL random_cyc%0d got=%b/%h/%h/%h want=%b/%h/%h/%h", i, enable, gfx_bitmap,
                 gfx_foreground, gfx_background, exp_en, exp_bmp, exp_fg, exp_bg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_mosaic();
    test_dbl_height();
    test_boundaries();
    test_hold();
    test_reset_midstream();
    test_blink();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
